// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity receiver: FSM encodings,
// parity-sense constants and a clog2 helper for the bit counter width.
package serial_parity_rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam bit PAR_EVEN = 1'b1;
    localparam bit PAR_ODD  = 1'b0;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_parity_rx_ser_shift.sv
// WIDTH-bit right-shift register (sn74164 style): serial bit enters the MSB,
// async active-low clear, synchronous clear has priority over shift.
module ser_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             sclr,
    input  logic             shift,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (sclr)
            q_d = '0;
        else if (shift)
            q_d = {d, q_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: WIDTH data bits LSB first plus one parity bit,
// deserialised into Q with running parity check and a RDY/ACK handshake.
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit EVEN  = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR_BAR,
    input  logic             START,
    input  logic             EN,
    input  logic             D,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             RDY,
    output logic             PERR,
    output logic             BUSY
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    // Odd parity expects data^parity == 1, even expects 0.
    localparam logic EXP_PAR = (EVEN == PAR_ODD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             rdy_q, rdy_d;
    logic             perr_q, perr_d;
    logic             busy_q, busy_d;
    logic             sclr, shift;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        rdy_d   = rdy_q;
        perr_d  = perr_q;
        busy_d  = busy_q;
        sclr    = 1'b0;
        shift   = 1'b0;

        case (state_q)
            S_IDLE, S_RECV, S_DONE: begin
                // START wins over EN and ACK in every state.
                if (START) begin
                    state_d = S_RECV;
                    sclr    = 1'b1;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    rdy_d   = 1'b0;
                    perr_d  = 1'b0;
                    busy_d  = 1'b1;
                end else if (state_q == S_RECV && EN) begin
                    if (cnt_q == CNT_LAST) begin
                        perr_d  = (par_q ^ D) != EXP_PAR;
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        shift = 1'b1;
                        par_d = par_q ^ D;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (state_q == S_DONE && ACK) begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                rdy_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            rdy_q   <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            rdy_q   <= rdy_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    ser_shift #(.WIDTH(WIDTH)) u_shift (
        .clk     (CLK),
        .clr_bar (CLR_BAR),
        .sclr    (sclr),
        .shift   (shift),
        .d       (D),
        .q       (Q)
    );

    assign RDY  = rdy_q;
    assign PERR = perr_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx (WIDTH=8, even parity): a vector table
// of per-cycle inputs/expected outputs plus hand sequences for async clear.
module tb_serial_parity_rx;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             CLR_BAR = 1'b0;
    logic             START = 1'b0;
    logic             EN = 1'b0;
    logic             D = 1'b0;
    logic             ACK = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             RDY, PERR, BUSY;

    int errors = 0;
    int checks = 0;

    serial_parity_rx #(.WIDTH(WIDTH), .EVEN(1'b1)) dut (
        .CLK     (CLK),
        .CLR_BAR (CLR_BAR),
        .START   (START),
        .EN      (EN),
        .D       (D),
        .ACK     (ACK),
        .Q       (Q),
        .RDY     (RDY),
        .PERR    (PERR),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       start, en, d, ack;
        logic [7:0] q;
        logic       rdy, perr, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string name, input logic start, input logic en,
                                input logic d, input logic ack, input logic [7:0] q,
                                input logic rdy, input logic perr, input logic busy);
        vec_t v;
        v.name = name; v.start = start; v.en = en; v.d = d; v.ack = ack;
        v.q = q; v.rdy = rdy; v.perr = perr; v.busy = busy;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] q, input logic rdy,
                         input logic perr, input logic busy);
        checks++;
        if ({Q, RDY, PERR, BUSY} !== {q, rdy, perr, busy}) begin
            errors++;
            $display("FAIL %s: got Q=%h RDY=%b PERR=%b BUSY=%b, want Q=%h RDY=%b PERR=%b BUSY=%b",
                     name, Q, RDY, PERR, BUSY, q, rdy, perr, busy);
        end
    endtask

    task automatic step(input logic start, input logic en, input logic d, input logic ack);
        @(negedge CLK);
        START = start; EN = en; D = d; ACK = ack;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] a5_bits, a5_q[8], c3_bits, c3_q[8], ff_q[8], one_q[8];

        a5_bits = 8'b1010_0101;   // index 7 sent first: 1,0,1,0,0,1,0,1
        a5_q    = '{8'h80, 8'h40, 8'hA0, 8'h50, 8'h28, 8'h94, 8'h4A, 8'hA5};
        c3_bits = 8'b0011_1100;   // 0,0,1,1,1,1,0,0
        c3_q    = '{8'h00, 8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'h78, 8'h3C};
        ff_q    = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        one_q   = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

        // Frame A5, good parity, then hold in DONE.
        add("a5_start", 1, 0, 0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add("a5_bit", 0, 1, a5_bits[7-i], 0, a5_q[i], 0, 0, 1);
        add("a5_par", 0, 1, 0, 0, 8'hA5, 1, 0, 0);
        add("a5_hold", 0, 1, 1, 0, 8'hA5, 1, 0, 0);

        // Same frame, bad parity; START straight from DONE.
        add("a5e_start", 1, 0, 0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add("a5e_bit", 0, 1, a5_bits[7-i], 0, a5_q[i], 0, 0, 1);
        add("a5e_par", 0, 1, 1, 0, 8'hA5, 1, 1, 0);
        add("a5e_ack", 0, 0, 0, 1, 8'hA5, 0, 1, 0);
        add("idle_ignore", 0, 1, 1, 1, 8'hA5, 0, 1, 0);

        // Frame 3C with two EN=0 cycles before every bit; ACK in RECV ignored.
        add("3c_start", 1, 0, 0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            add("3c_gap", 0, 0, 1, 1, (i == 0) ? 8'h00 : c3_q[i-1], 0, 0, 1);
            add("3c_gap", 0, 0, 0, 0, (i == 0) ? 8'h00 : c3_q[i-1], 0, 0, 1);
            add("3c_bit", 0, 1, c3_bits[7-i], 0, c3_q[i], 0, 0, 1);
        end
        add("3c_gap", 0, 0, 1, 0, 8'h3C, 0, 0, 1);
        add("3c_gap", 0, 0, 1, 0, 8'h3C, 0, 0, 1);
        add("3c_par", 0, 1, 0, 0, 8'h3C, 1, 0, 0);
        add("3c_ack", 0, 0, 0, 1, 8'h3C, 0, 0, 0);
        add("3c_idle", 0, 0, 0, 0, 8'h3C, 0, 0, 0);

        // Restart mid-frame; the START cycle's EN bit is discarded.
        add("rs_start", 1, 0, 0, 0, 8'h00, 0, 0, 1);
        add("rs_bit", 0, 1, 1, 0, 8'h80, 0, 0, 1);
        add("rs_bit", 0, 1, 1, 0, 8'hC0, 0, 0, 1);
        add("rs_bit", 0, 1, 0, 0, 8'h60, 0, 0, 1);
        add("rs_restart", 1, 1, 1, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add("ff_bit", 0, 1, 1, 0, ff_q[i], 0, 0, 1);
        add("ff_par", 0, 1, 0, 0, 8'hFF, 1, 0, 0);

        // START and ACK together in DONE: START wins.
        add("coll", 1, 0, 0, 1, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            add("01_bit", 0, 1, (i == 0), 0, one_q[i], 0, 0, 1);
        add("01_par", 0, 1, 1, 0, 8'h01, 1, 0, 0);

        // Reset, then an async pulse mid-clock.
        #12;
        check("reset", 8'h00, 0, 0, 0);
        CLR_BAR = 1'b1;
        @(posedge CLK); #3;
        CLR_BAR = 1'b0;
        #1;
        check("clr_pulse", 8'h00, 0, 0, 0);
        CLR_BAR = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].start, tbl[i].en, tbl[i].d, tbl[i].ack);
            check(tbl[i].name, tbl[i].q, tbl[i].rdy, tbl[i].perr, tbl[i].busy);
        end

        // Async clear after 5 bits, no clock edge needed.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
        check("pre_clr", 8'hF8, 0, 0, 1);
        #2;
        CLR_BAR = 1'b0;
        #1;
        check("async_clr", 8'h00, 0, 0, 0);
        @(negedge CLK);
        CLR_BAR = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 1, 0);
            check("no_start", 8'h00, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
